// File: rtl/rsc_parity_checker.sv
// rsc_parity_checker: re-encodes received systematic bits, counts parity mismatches, checks trellis termination.
// Optional macro ERR_SAT_EN: saturating err_count plus sticky err_sat output.
module rsc_parity_checker #(
  parameter int K_SMALL = 1056,
  parameter int K_LARGE = 6144,
  parameter int ERR_W   = 13
) (
  input  logic             clk,
  input  logic             aclr_n,
  input  logic             start,
  input  logic             k_sel,
  input  logic             in_valid,
  input  logic             xk,
  input  logic             zk,
  output logic             dk,
  output logic             dk_valid,
  output logic             busy,
  output logic             done,
  output logic [ERR_W-1:0] err_count,
  output logic             tail_err,
  output logic             term_ok
`ifdef ERR_SAT_EN
  ,
  output logic             err_sat
`endif
);
  localparam int CW = $clog2(K_LARGE);
  typedef enum logic [1:0] {IDLE, DATA, TAIL, DONE} state_t;
  state_t state_q, state_d;
  logic k_q, k_d;
  logic [2:0] q_q, q_d;
  logic [CW-1:0] cnt_q, cnt_d, k_last;
  logic dk_q, dk_d, dk_valid_q, dk_valid_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic tail_err_q, tail_err_d, term_ok_q, term_ok_d;
  logic s, exp_x, exp_z, data_bit, tail_bit, z_miss;
`ifdef ERR_SAT_EN
  logic err_sat_q, err_sat_d;
`endif
  always_comb begin
    k_last = k_q ? CW'(K_LARGE - 1) : CW'(K_SMALL - 1);
    s = xk ^ q_q[1] ^ q_q[2];
    exp_x = q_q[1] ^ q_q[2];
    exp_z = q_q[0] ^ q_q[2];
    data_bit = state_q == DATA && in_valid && !start;
    tail_bit = state_q == TAIL && in_valid && !start;
    // in DATA the expected parity also folds in the feedback bit s
    z_miss = data_bit ? (zk != (s ^ exp_z)) : (tail_bit && zk != exp_z);
    state_d = state_q;
    k_d = k_q;
    q_d = q_q;
    cnt_d = cnt_q;
    dk_d = data_bit ? xk : dk_q;
    dk_valid_d = data_bit;
    err_d = err_q;
    tail_err_d = tail_err_q;
    term_ok_d = term_ok_q;
`ifdef ERR_SAT_EN
    err_sat_d = err_sat_q;
`endif
    if (start) begin
      state_d = DATA;
      k_d = k_sel;
      q_d = '0;
      cnt_d = '0;
      err_d = '0;
      tail_err_d = 1'b0;
      term_ok_d = 1'b0;
`ifdef ERR_SAT_EN
      err_sat_d = 1'b0;
`endif
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end else if (data_bit) begin
      q_d = {q_q[1], q_q[0], s};
      cnt_d = cnt_q == k_last ? '0 : cnt_q + 1'b1;
      state_d = cnt_q == k_last ? TAIL : DATA;
    end else if (tail_bit) begin
      q_d = {q_q[1], q_q[0], 1'b0};
      tail_err_d = tail_err_q | (xk != exp_x) | (zk != exp_z);
      cnt_d = cnt_q == CW'(2) ? '0 : cnt_q + 1'b1;
      state_d = cnt_q == CW'(2) ? DONE : TAIL;
    end
`ifdef ERR_SAT_EN
    if (z_miss) begin
      err_d = &err_q ? err_q : err_q + 1'b1;
      err_sat_d = err_sat_q | (&err_d);
    end
`else
    if (z_miss) err_d = err_q + 1'b1;
`endif
    if (tail_bit && cnt_q == CW'(2)) term_ok_d = q_d == '0 && err_d == '0 && !tail_err_d;
  end
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q <= IDLE;
      k_q <= 1'b0;
      q_q <= '0;
      cnt_q <= '0;
      dk_q <= 1'b0;
      dk_valid_q <= 1'b0;
      err_q <= '0;
      tail_err_q <= 1'b0;
      term_ok_q <= 1'b0;
`ifdef ERR_SAT_EN
      err_sat_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      q_q <= q_d;
      cnt_q <= cnt_d;
      dk_q <= dk_d;
      dk_valid_q <= dk_valid_d;
      err_q <= err_d;
      tail_err_q <= tail_err_d;
      term_ok_q <= term_ok_d;
`ifdef ERR_SAT_EN
      err_sat_q <= err_sat_d;
`endif
    end
  end
  assign dk = dk_q;
  assign dk_valid = dk_valid_q;
  assign busy = state_q == DATA || state_q == TAIL;
  assign done = state_q == DONE;
  assign err_count = err_q;
  assign tail_err = tail_err_q;
  assign term_ok = term_ok_q;
`ifdef ERR_SAT_EN
  assign err_sat = err_sat_q;
`endif
endmodule

// File: tb/tb_rsc_parity_checker.sv
// tb_rsc_parity_checker: scoreboard bench; golden RSC stream built from the recurrence a[k]=x[k]^a[k-2]^a[k-3].
module tb_rsc_parity_checker;
  localparam int KS = 1056;
  localparam int KL = 6144;
  logic clk = 0;
  logic aclr_n = 0;
  logic start = 0;
  logic k_sel = 0;
  logic in_valid = 0;
  logic xk = 0;
  logic zk = 0;
  logic dk, dk_valid, busy, done, tail_err, term_ok;
  logic [12:0] err_count;
`ifdef ERR_SAT_EN
  logic err_sat;
`endif
  rsc_parity_checker dut (
    .clk(clk), .aclr_n(aclr_n), .start(start), .k_sel(k_sel), .in_valid(in_valid),
    .xk(xk), .zk(zk), .dk(dk), .dk_valid(dk_valid), .busy(busy), .done(done),
    .err_count(err_count), .tail_err(tail_err), .term_ok(term_ok)
`ifdef ERR_SAT_EN
    , .err_sat(err_sat)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {int err; bit te; bit ok; int dcyc;} res_t;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nvalid = 0;
  int last_done_cyc = 0;
  bit exp_dk[$];
  res_t exp_res[$];
  res_t mr;
  bit xs[KL+3];
  bit zs[KL+3];
  bit aa[KL+6];
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (dk_valid) begin
      nvalid++;
      if (exp_dk.size() == 0) chk("dk_unexpected", 1, 0);
      else chk("dk", int'(dk), int'(exp_dk.pop_front()));
    end
    if (done) begin
      last_done_cyc = cyc;
      if (exp_res.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        mr = exp_res.pop_front();
        chk("err_count", int'(err_count), mr.err);
        chk("tail_err", int'(tail_err), int'(mr.te));
        chk("term_ok", int'(term_ok), int'(mr.ok));
        chk("done_cycle", cyc, mr.dcyc);
        chk("busy_at_done", int'(busy), 0);
      end
    end
  end
  // mode: 0 all-zero, 1 golden random, 2 parity flips at 5/700, 3 2nd tail x flipped, 4 random flips
  task automatic run_block(input bit ks, input int mode, input bit gap, input int abort_at, output int start_cyc);
    int k;
    int errs;
    bit te;
    res_t r;
    k = ks ? KL : KS;
    errs = 0;
    te = 0;
    for (int j = 0; j < 3; j++) aa[j] = 0;
    for (int i = 0; i < k; i++) begin
      xs[i] = mode == 0 ? 1'b0 : 1'($urandom_range(0, 1));
      aa[i+3] = xs[i] ^ aa[i+1] ^ aa[i];
      zs[i] = aa[i+3] ^ aa[i+2] ^ aa[i];
    end
    for (int i = k; i < k + 3; i++) begin
      xs[i] = aa[i+1] ^ aa[i];
      aa[i+3] = 0;
      zs[i] = aa[i+2] ^ aa[i];
    end
    if (mode == 2) begin
      zs[5] = ~zs[5];
      zs[700] = ~zs[700];
    end
    if (mode == 3) xs[k+1] = ~xs[k+1];
    if (mode == 4) begin
      repeat ($urandom_range(1, 20)) begin
        int idx;
        idx = $urandom_range(0, k + 2);
        if ($urandom_range(0, 1) == 1) xs[idx] = ~xs[idx];
        else zs[idx] = ~zs[idx];
      end
    end
    for (int j = 0; j < 3; j++) aa[j] = 0;
    for (int i = 0; i < k; i++) begin
      aa[i+3] = xs[i] ^ aa[i+1] ^ aa[i];
      if (zs[i] != (aa[i+3] ^ aa[i+2] ^ aa[i])) errs++;
    end
    for (int i = k; i < k + 3; i++) begin
      aa[i+3] = 0;
      if (xs[i] != (aa[i+1] ^ aa[i])) te = 1;
      if (zs[i] != (aa[i+2] ^ aa[i])) begin
        te = 1;
        errs++;
      end
    end
    start = 1;
    k_sel = ks;
    in_valid = 1'($urandom_range(0, 1));
    xk = 1'($urandom_range(0, 1));
    zk = 1'($urandom_range(0, 1));
    start_cyc = cyc;
    tick;
    start = 0;
    for (int i = 0; i < k + 3; i++) begin
      if (i == abort_at) begin
        in_valid = 0;
        return;
      end
      if (gap && cyc % 3 == 0) begin
        in_valid = 0;
        xk = 1'($urandom_range(0, 1));
        zk = 1'($urandom_range(0, 1));
        tick;
      end
      in_valid = 1;
      xk = xs[i];
      zk = zs[i];
      if (i < k) exp_dk.push_back(xs[i]);
      if (i == k + 2) begin
        r.err = errs;
        r.te = te;
        r.ok = errs == 0 && !te;
        r.dcyc = cyc + 1;
        exp_res.push_back(r);
      end
      tick;
    end
    in_valid = 0;
  endtask
  task automatic wait_idle;
    for (int i = 0; i < 50 && (exp_res.size() > 0 || exp_dk.size() > 0); i++) tick;
    if (exp_res.size() != 0) begin
      chk("done_timeout", exp_res.size(), 0);
      exp_res.delete();
    end
    chk("dk_drain", exp_dk.size(), 0);
    exp_dk.delete();
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int sc;
    int nv0;
    aclr_n = 0;
    repeat (2) tick;
    chk("reset_outputs", int'({dk, dk_valid, busy, done, err_count, tail_err, term_ok}), 0);
    aclr_n = 1;
    tick;
    nv0 = nvalid;
    run_block(0, 0, 0, -1, sc);
    wait_idle;
    chk("t1_dk_count", nvalid - nv0, KS);
    chk("t1_done_latency", last_done_cyc - sc, 1060);
    run_block(1, 1, 0, -1, sc);
    wait_idle;
    run_block(1, 2, 0, -1, sc);
    wait_idle;
    repeat (3) tick;
    chk("t3_err_hold", int'(err_count), 2);
    chk("t3_term_ok_hold", int'(term_ok), 0);
    run_block(0, 3, 0, -1, sc);
    wait_idle;
    run_block(0, 1, 1, 400, sc);
    run_block(0, 1, 1, -1, sc);
    wait_idle;
    run_block(0, 1, 0, 200, sc);
    #1 aclr_n = 0;
    #1 chk("aclr_outputs", int'({dk, dk_valid, busy, done, err_count, tail_err, term_ok}), 0);
    exp_dk.delete();
    tick;
    aclr_n = 1;
    tick;
    chk("aclr_idle", int'({busy, done}), 0);
    run_block(0, 1, 0, -1, sc);
    wait_idle;
    run_block(0, 1, 0, -1, sc);
    run_block(0, 4, 0, -1, sc);
    wait_idle;
    for (int t = 0; t < 4; t++) begin
      run_block(t == 3, 4, 1'($urandom_range(0, 1)), -1, sc);
    end
    wait_idle;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
